// File: rtl/seq_mult16.sv
// Sequential shift-and-add multiplier.
// Signed operands are reduced to magnitudes, multiplied unsigned over WIDTH
// CALC cycles, and the sign is re-applied in a single FIX cycle.
// Prod/Zero are updated only in FIX and otherwise hold their last result.
module seq_mult16 #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               signed_op,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] Prod,
  output logic               Zero
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [PW-1:0]    r_acc;
  logic [PW-1:0]    r_prod;
  logic [CW-1:0]    r_count;
  logic             r_neg;
  logic             r_busy;
  logic             r_done;
  logic             r_zero;

  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;
  logic             w_neg;
  logic [PW-1:0]    w_partial;
  logic [PW-1:0]    w_fixed;

  // Magnitudes: the most negative value negates to itself, which read as
  // unsigned is exactly its magnitude, so no extra bit is needed.
  assign w_a_mag = (signed_op && A[WIDTH-1]) ? (~A + WIDTH'(1)) : A;
  assign w_b_mag = (signed_op && B[WIDTH-1]) ? (~B + WIDTH'(1)) : B;
  assign w_neg   = signed_op & (A[WIDTH-1] ^ B[WIDTH-1]);

  // Partial product for this CALC step: multiplicand weighted by the bit index.
  assign w_partial = r_mplier[0] ? ({{WIDTH{1'b0}}, r_mcand} << r_count) : '0;

  // Final result with the sign restored (two's complement, modulo 2^PW).
  assign w_fixed = r_neg ? (~r_acc + PW'(1)) : r_acc;

  assign busy = r_busy;
  assign done = r_done;
  assign Prod = r_prod;
  assign Zero = r_zero;

  // Control FSM and datapath; all outputs are registered here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_prod   <= '0;
      r_count  <= '0;
      r_neg    <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_zero   <= 1'b1;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          r_done <= 1'b0;
          if (start) begin
            r_mcand  <= w_a_mag;
            r_mplier <= w_b_mag;
            r_neg    <= w_neg;
            r_acc    <= '0;
            r_count  <= '0;
            r_busy   <= 1'b1;
            r_state  <= CALC;
          end else begin
            r_state  <= IDLE;
          end
        end
        CALC: begin
          r_acc    <= r_acc + w_partial;
          r_mplier <= r_mplier >> 1;
          r_count  <= r_count + CW'(1);
          if (r_count == CW'(WIDTH - 1)) begin
            r_state <= FIX;
          end
        end
        FIX: begin
          r_prod  <= w_fixed;
          r_zero  <= (w_fixed[WIDTH-1:0] == '0);
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_state <= DONE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule
